// File: rtl/axi_write_master_pkg.sv
// Shared encodings for the AXI3 write master: FSM states, burst/response codes and the
// latched request record.
package axi_write_master_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic [1:0]  burst;
  } wr_req_t;

  // The reserved 2'b11 encoding is never put on the bus; it is issued as INCR.
  function automatic logic [1:0] legal_burst(input logic [1:0] burst);
    logic [1:0] res;
    unique case (burst)
      BURST_FIXED: res = BURST_FIXED;
      BURST_WRAP:  res = BURST_WRAP;
      default:     res = BURST_INCR;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] resp_for(input logic [3:0] bid, input logic [3:0] id,
                                          input logic [1:0] bresp);
    return (bid == id) ? bresp : SLVERR;
  endfunction

endpackage

// File: rtl/axi_write_master_wdata_fifo.sv
// Synchronous write-data FIFO (strobe + data per entry) with full/empty flags.
// A push while full is dropped even if a pop happens in the same cycle.
module axi_wdata_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == DepthC);
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge ACLK) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_write_master.sv
// AXI3 write master: takes one device request plus buffered data beats, issues the AW
// burst, streams W beats from the FIFO, then consumes B and pulses done.
module axi_write_master
  import axi_write_master_pkg::*;
#(
  parameter int unsigned buswidth   = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [3:0]          req_id,
  input  logic [3:0]          req_len,
  input  logic [1:0]          req_burst,
  input  logic [buswidth-1:0] wdata_in,
  input  logic [3:0]          wstrb_in,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic [3:0]          AWID,
  output logic [31:0]         AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [1:0]          AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [3:0]          WID,
  output logic [buswidth-1:0] WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int unsigned FifoW = buswidth + 4;

  logic [1:0]       state_q, state_d;
  wr_req_t          req_q;
  logic [3:0]       beat_cnt_q;
  logic             done_q;
  logic [1:0]       done_resp_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FifoW-1:0] fifo_rdata;

  logic             req_hs, aw_hs, w_hs, b_hs;

  assign req_ready   = ARESETn && (state_q == StIdle);
  assign wdata_ready = ARESETn && !fifo_full;
  assign fifo_push   = wdata_valid && wdata_ready;
  assign fifo_pop    = w_hs;

  assign req_hs = req_valid && req_ready;
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BVALID && BREADY;

  axi_wdata_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_wdata_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push_i  (fifo_push),
    .wdata_i ({wstrb_in, wdata_in}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_hs) state_d = StAddr;
      StAddr:  if (aw_hs) state_d = StData;
      StData:  if (w_hs && WLAST) state_d = StResp;
      StResp:  if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      req_q       <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      done_resp_q <= OKAY;
    end else begin
      state_q <= state_d;
      done_q  <= b_hs;
      if (req_hs) begin
        req_q.addr  <= req_addr;
        req_q.id    <= req_id;
        req_q.len   <= req_len;
        req_q.burst <= legal_burst(req_burst);
        beat_cnt_q  <= '0;
      end else if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + 4'd1;
      end
      if (b_hs) done_resp_q <= resp_for(BID, req_q.id, BRESP);
    end
  end

  // Address channel: fields come straight from the latched request, so they stay
  // stable for as long as AWVALID is held.
  assign AWVALID = (state_q == StAddr);
  assign AWID    = req_q.id;
  assign AWADDR  = req_q.addr;
  assign AWLEN   = req_q.len;
  assign AWBURST = req_q.burst;
  assign AWSIZE  = AWVALID ? AXI_SIZE_4B : 3'd0;
  assign AWLOCK  = 2'b00;
  assign AWCACHE = 4'b0000;
  assign AWPROT  = 3'b000;

  // Data channel: the FIFO head only moves on a handshake, which keeps a stalled beat stable.
  assign WVALID = (state_q == StData) && !fifo_empty;
  assign WID    = req_q.id;
  assign WDATA  = WVALID ? fifo_rdata[buswidth-1:0] : '0;
  assign WSTRB  = WVALID ? fifo_rdata[FifoW-1:buswidth] : 4'b0000;
  assign WLAST  = WVALID && (beat_cnt_q == req_q.len);

  assign BREADY    = (state_q == StResp);
  assign done      = done_q;
  assign done_resp = done_resp_q;

endmodule
